// File: rtl/keypad_pkg.sv
// Shared widths, the "no key" candidate sentinel and debounce state encoding
// for the 4x4 keypad scan controller.
package keypad_pkg;
  localparam int KEY_W    = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int CAND_W   = KEY_W + 1;

  // Bit 4 set means "no single key" (nothing pressed, or several at once)
  localparam logic [CAND_W-1:0] KEY_NONE = 5'h10;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_CHK,
    DB_HELD,
    DB_RELEASE_CHK
  } db_state_e;

  // Reduce a full-matrix snapshot to one key code, or KEY_NONE unless exactly one bit is set
  function automatic logic [CAND_W-1:0] map_to_cand(input logic [NUM_KEYS-1:0] m);
    logic [CAND_W-1:0] c;
    int                n;
    c = KEY_NONE;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (m[i]) begin
        n++;
        c = CAND_W'(i);
      end
    end
    return (n == 1) ? c : KEY_NONE;
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Per-scan debounce FSM: turns a stream of per-scan candidates into press
// events and a held level. Auto-repeat is built only with KEYPAD_REPEAT_EN.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_done,
  input  logic [CAND_W-1:0] cand,
  output logic              evt,
  output logic [KEY_W-1:0]  evt_code,
  output logic              key_down
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             down_q, down_d;
  logic             match;

`ifdef KEYPAD_REPEAT_EN
  localparam int               RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int               RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  assign match    = (cand == {1'b0, key_q});
  assign evt_code = key_d;
  assign key_down = down_q;

  // Next-state: only scan_done cycles move the FSM; accepting a key emits evt
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    down_d  = down_q;
    evt     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (scan_done) begin
      case (state_q)
        DB_IDLE: begin
          if (cand != KEY_NONE) begin
            key_d = cand[KEY_W-1:0];
            if (DEBOUNCE_SCANS == 1) begin
              state_d = DB_HELD;
              cnt_d   = '0;
              down_d  = 1'b1;
              evt     = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rpt_d   = RPT_W'(REPEAT_DELAY);
`endif
            end else begin
              state_d = DB_PRESS_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        DB_PRESS_CHK: begin
          if (cand == KEY_NONE) begin
            state_d = DB_IDLE;
            cnt_d   = '0;
          end else if (!match) begin
            key_d = cand[KEY_W-1:0];
            cnt_d = CNT_ONE;
          end else if (cnt_q + CNT_ONE == CNT_LAST) begin
            state_d = DB_HELD;
            cnt_d   = '0;
            down_d  = 1'b1;
            evt     = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rpt_d   = RPT_W'(REPEAT_DELAY);
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DB_HELD: begin
          if (!match) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = DB_IDLE;
              cnt_d   = '0;
              down_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              state_d = DB_RELEASE_CHK;
              cnt_d   = CNT_ONE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rpt_q == RPT_ONE) begin
            evt   = 1'b1;
            rpt_d = RPT_W'(REPEAT_RATE);
          end else begin
            rpt_d = rpt_q - RPT_ONE;
          end
`endif
        end
        default: begin  // DB_RELEASE_CHK: repeat counter is frozen here
          if (match) begin
            state_d = DB_HELD;
            cnt_d   = '0;
          end else if (cnt_q + CNT_ONE == CNT_LAST) begin
            state_d = DB_IDLE;
            cnt_d   = '0;
            down_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      down_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      down_q  <= down_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: column sequencer, full-matrix snapshot,
// debounce and a single-entry valid/ready output buffer.
// Optional auto-repeat: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_down,
  output logic                key_overflow
);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_q, col_d;
  logic [NUM_KEYS-1:0] map_q, map_d;
  logic [NUM_KEYS-1:0] snap;
  logic [CAND_W-1:0]   cand_q, cand_d;
  logic                scan_done_q, scan_done_d;
  logic                div_last;
  logic                valid_q, valid_d;
  logic [KEY_W-1:0]    code_q, code_d;
  logic                ovf_q, ovf_d;
  logic                db_evt;
  logic [KEY_W-1:0]    db_code;

  assign cols         = ~(NUM_COLS'(1) << col_q);
  assign key_code     = code_q;
  assign key_valid    = valid_q;
  assign key_overflow = ovf_q;

  // Sequencer and snapshot: rows are sampled on the last divider cycle of a
  // column so the strobe has settled; the candidate is registered at end of scan
  always_comb begin
    div_last    = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d       = div_last ? '0 : div_q + DIV_W'(1);
    col_d       = div_last ? col_q + 2'd1 : col_q;
    snap        = map_q;
    if (div_last) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!rows[r]) snap[r*NUM_COLS + int'(col_q)] = 1'b1;
      end
    end
    map_d       = snap;
    cand_d      = cand_q;
    scan_done_d = 1'b0;
    if (div_last && (col_q == 2'd3)) begin
      map_d       = '0;
      cand_d      = map_to_cand(snap);
      scan_done_d = 1'b1;
    end
  end

  // Output buffer: a new event while the old one is stalled is dropped
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
    if (db_evt) begin
      if (valid_q && !key_ready) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = db_code;
      end
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  // Sequencer, snapshot and buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      col_q       <= '0;
      map_q       <= '0;
      cand_q      <= KEY_NONE;
      scan_done_q <= 1'b0;
      valid_q     <= 1'b0;
      code_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      map_q       <= map_d;
      cand_q      <= cand_d;
      scan_done_q <= scan_done_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      ovf_q       <= ovf_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_RATE   (REPEAT_RATE)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .scan_done(scan_done_q),
    .cand     (cand_q),
    .evt      (db_evt),
    .evt_code (db_code),
    .key_down (key_down)
  );
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed scenarios plus random key maps,
// checked against a scan-level run-length model and an event scoreboard.
module tb_keypad_scan_ctrl;
  localparam int SDIV = 4;
  localparam int DEB  = 3;
  localparam int RD   = 4;
  localparam int RR   = 2;
  localparam int SCAN = 4 * SDIV;
  localparam int NONE_K = 16;

  logic       clk, rst, key_ready;
  logic [3:0] rows, cols, key_code;
  logic       key_valid, key_down, key_overflow;

  logic [15:0] cur_map;
  int          rdy_mode;
  int          errors, checks;

  keypad_scan_ctrl #(
    .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_down(key_down),
    .key_overflow(key_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad: a pressed key at (r,c) pulls row r low while column c is strobed
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!cols[c])
        for (int r = 0; r < 4; r++)
          if (cur_map[r*4 + c]) rows[r] = 1'b0;
  end

  // Consumer ready, changed just after each rising edge
  initial begin
    key_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       key_ready = 1'b0;
        1:       key_ready = 1'b1;
        default: key_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cand_of(input logic [15:0] m);
    if ($countones(m) != 1) return NONE_K;
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return NONE_K;
  endfunction

  function automatic logic [3:0] exp_cols(input int cyc_n);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((cyc_n / SDIV) % 4));
  endfunction

  // ---------------- reference model (scan-level run lengths) ----------------
  logic [15:0] map_fifo[$];
  int          exp_q[$];
  int          cyc;
  bit          m_valid, m_ovf, m_held;
  int          m_code;
  int          run, rk, hk, away, since, ev, ek, cnd;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        cyc = 0; m_valid = 0; m_ovf = 0; m_held = 0; m_code = 0;
        run = 0; rk = -1; hk = -1; away = 0; since = 0;
        exp_q.delete();
      end else begin
        cyc++;
        ev = 0; ek = 0;
        // the scan ending at edge SCAN*n is judged one edge later
        if (cyc > 1 && (cyc - 1) % SCAN == 0) begin
          cnd = (map_fifo.size() > 0) ? cand_of(map_fifo.pop_front()) : NONE_K;
          if (!m_held) begin
            if (cnd == NONE_K) run = 0;
            else if (run > 0 && cnd == rk) run++;
            else begin rk = cnd; run = 1; end
            if (run == DEB) begin
              m_held = 1; hk = cnd; away = 0; since = 0; run = 0;
              ev = 1; ek = cnd;
            end
          end else if (cnd != hk) begin
            away++;
            if (away == DEB) begin m_held = 0; away = 0; run = 0; end
          end else if (away > 0) begin
            away = 0;
          end else begin
            since++;
`ifdef KEYPAD_REPEAT_EN
            if (since == RD || (since > RD && (since - RD) % RR == 0)) begin
              ev = 1; ek = hk;
            end
`endif
          end
        end
        m_ovf = 0;
        if (ev != 0) begin
          if (m_valid && !key_ready) m_ovf = 1;
          else begin m_valid = 1; m_code = ek; exp_q.push_back(ek); end
        end else if (m_valid && key_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int  rise_q[$];
  int  nhs, novf, hs_code;
  bit  prev_valid;

  initial begin
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cols", cols, exp_cols(cyc));
        chk("key_valid", key_valid, m_valid);
        chk("key_down", key_down, m_held);
        chk("key_overflow", key_overflow, m_ovf);
        if (key_valid) chk("key_code", key_code, m_code);
        if (key_valid && !prev_valid) rise_q.push_back(cyc);
        if (key_overflow) novf++;
        if (key_valid && key_ready) begin
          nhs++;
          hs_code = key_code;
          if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
          else chk("sb_code", key_code, exp_q.pop_front());
        end
      end
      prev_valid = key_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int mode);
    rst = 1'b1;
    cur_map = '0;
    rdy_mode = mode;
    repeat (2) @(negedge clk);
    chk("rst_cols", cols, 14);
    chk("rst_valid", key_valid, 0);
    chk("rst_down", key_down, 0);
    chk("rst_ovf", key_overflow, 0);
    chk("rst_code", key_code, 0);
    map_fifo.delete();
    rise_q.delete();
    nhs = 0; novf = 0; hs_code = -1;
    rst = 1'b0;
  endtask

  task automatic run_scan(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      cur_map = m;
      map_fifo.push_back(m);
      repeat (SCAN) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] m, prev_m;
    errors = 0; checks = 0;
    rst = 1'b1; cur_map = '0; rdy_mode = 0;

    // 1: idle keypad, column walk only
    do_reset(1);
    run_scan(16'h0000, 13);
    chk("t1_events", nhs, 0);

    // 2: key 6 held from reset
    do_reset(1);
    run_scan(16'h0040, 6);
    chk("t2_rise", (rise_q.size() > 0) ? rise_q[0] : -1, 49);
    chk("t2_events", nhs, 1);

    // 3: key 6 bounces out in scan 3
    do_reset(1);
    run_scan(16'h0040, 2);
    run_scan(16'h0000, 1);
    run_scan(16'h0040, 6);
    chk("t3_rise", (rise_q.size() > 0) ? rise_q[0] : -1, 97);
    chk("t3_events", nhs, 1);

    // 4: stalled consumer, second press overflows, then drain
    do_reset(0);
    run_scan(16'h0008, 5);
    run_scan(16'h0000, 5);
    run_scan(16'h0200, 5);
    chk("t4_ovf", novf, 1);
    chk("t4_held_valid", key_valid, 1);
    rdy_mode = 1;
    run_scan(16'h0000, 3);
    chk("t4_events", nhs, 1);
    chk("t4_code", hs_code, 3);

    // 5: two keys at once are ignored
    do_reset(1);
    run_scan(16'h0021, 8);
    chk("t5_events", nhs, 0);
    chk("t5_down", key_down, 0);

`ifdef KEYPAD_REPEAT_EN
    // 6: auto-repeat on key 15
    do_reset(1);
    run_scan(16'h8000, 12);
    chk("t6_events", nhs, 4);
    chk("t6_rise0", (rise_q.size() > 0) ? rise_q[0] : -1, 49);
    chk("t6_rise1", (rise_q.size() > 1) ? rise_q[1] : -1, 113);
    chk("t6_rise2", (rise_q.size() > 2) ? rise_q[2] : -1, 145);
    chk("t6_rise3", (rise_q.size() > 3) ? rise_q[3] : -1, 177);
`endif

    // 7: random maps, random consumer
    do_reset(2);
    prev_m = '0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       m = '0;
        1:       m = prev_m;
        2, 3:    m = 16'h0001 << $urandom_range(0, 15);
        default: m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      run_scan(m, $urandom_range(1, 6));
      prev_m = m;
    end
    rdy_mode = 1;
    run_scan(16'h0000, 4);
    chk("t7_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
